ps2_key_event_queue: RTL and testbench

//  Parametrised successor to the single-scancode keyboard front end. Takes raw PS/2 bytes,

---
 rtl/ps2_key_event_queue.sv | 189 ++++++++++++++++++
 tb/tb_ps2_key_event_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ps2_key_event_queue                                              |
// | Purpose : PS/2 byte decoder with key-repeat filter feeding an event FIFO   |
// |           that the CPU drains through two ZX-Uno registers.                |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ps2_key_event_queue #(
    parameter int          DEPTH         = 8,
    parameter bit          FILTER_REPEAT = 1'b1,
    parameter logic [7:0]  REG_DATA      = 8'hF8,
    parameter logic [7:0]  REG_STAT      = 8'hF9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_valid,
    input  logic [7:0] scan_byte,
    input  logic [7:0] zxuno_addr,
    input  logic       zxuno_regrd,
    input  logic       zxuno_regwr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       oe,
    output logic       pending
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    logic             ext_q, ext_d, rel_q, rel_d;
    logic [2:0]       skip_q, skip_d;
    logic [255:0]     bitmap_q, bitmap_d;
    logic             ovf_q, ovf_d;
    logic             rd_data_q, rd_data_d;
    logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0]  cnt_q, cnt_d;
    logic [9:0]       mem_q [DEPTH];

    logic             ev_valid, ev_rel, ev_ext, repeat_drop, push, pop, mem_we;
    logic [7:0]       ev_code, key_idx;
    logic             ctrl_wr, rd_sel, empty, full;
    logic [9:0]       head;
    logic [4:0]       cnt_wide;
    logic [3:0]       stat_cnt;
    logic             unused_din;

    assign unused_din = ^din[5:0];

    // Prefix decoder: E1 starts a fixed 7-byte skip that ends in a synthetic Pause event.
    always_comb begin
        ev_valid = 1'b0;
        ev_rel   = 1'b0;
        ev_ext   = 1'b0;
        ev_code  = scan_byte;
        ext_d    = ext_q;
        rel_d    = rel_q;
        skip_d   = skip_q;
        if (scan_valid) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
                if (skip_q == 3'd1) begin
                    ev_valid = 1'b1;
                    ev_ext   = 1'b1;
                    ev_code  = 8'h77;
                end
            end else begin
                case (scan_byte)
                    8'hE0: ext_d = 1'b1;
                    8'hF0: rel_d = 1'b1;
                    8'hE1: begin
                        skip_d = 3'd7;
                        ext_d  = 1'b0;
                        rel_d  = 1'b0;
                    end
                    default: begin
                        ev_valid = 1'b1;
                        ev_rel   = rel_q;
                        ev_ext   = ext_q;
                        ext_d    = 1'b0;
                        rel_d    = 1'b0;
                    end
                endcase
            end
        end
    end

    assign ctrl_wr = zxuno_regwr && (zxuno_addr == REG_STAT);
    assign key_idx = {ev_ext, ev_code[6:0]};

    // Bitmap tracks held keys independently of whether the FIFO accepts the event.
    always_comb begin
        bitmap_d    = bitmap_q;
        repeat_drop = 1'b0;
        if (ev_valid && !ev_code[7]) begin
            if (ev_rel) begin
                bitmap_d[key_idx] = 1'b0;
            end else begin
                repeat_drop       = FILTER_REPEAT && bitmap_q[key_idx];
                bitmap_d[key_idx] = 1'b1;
            end
        end
        if (ctrl_wr && din[6]) begin
            bitmap_d = '0;
        end
    end

    assign push      = ev_valid && !repeat_drop;
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == c_cw'(DEPTH));
    assign rd_sel    = zxuno_regrd && (zxuno_addr == REG_DATA);
    assign rd_data_d = rd_sel;
    assign pop       = rd_data_q && !rd_sel && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        mem_we   = 1'b0;
        if (ctrl_wr && din[7]) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && full && !pop) begin
                ovf_d = 1'b1;
            end else if (push) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (mem_we && !pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!mem_we && pop) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q     <= 1'b0;
            rel_q     <= 1'b0;
            skip_q    <= 3'd0;
            bitmap_q  <= '0;
            ovf_q     <= 1'b0;
            rd_data_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            ext_q     <= ext_d;
            rel_q     <= rel_d;
            skip_q    <= skip_d;
            bitmap_q  <= bitmap_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= {ev_rel, ev_ext, ev_code};
        end
    end

    assign head     = empty ? 10'd0 : mem_q[rd_ptr_q];
    assign cnt_wide = 5'(cnt_q);
    assign stat_cnt = (cnt_wide > 5'd15) ? 4'hF : cnt_wide[3:0];
    assign pending  = !empty;
    assign oe       = zxuno_regrd && ((zxuno_addr == REG_DATA) || (zxuno_addr == REG_STAT));

    always_comb begin
        dout = 8'h00;
        if (zxuno_regrd && (zxuno_addr == REG_DATA)) begin
            dout = head[7:0];
        end else if (zxuno_regrd && (zxuno_addr == REG_STAT)) begin
            dout = {ovf_q, head[9], head[8], full, stat_cnt};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ps2_key_event_queue                                           |
// | Purpose : Directed and randomized bench against a queue-based key model.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_ps2_key_event_queue;

    localparam int         DEPTH    = 8;
    localparam logic [7:0] REG_DATA = 8'hF8;
    localparam logic [7:0] REG_STAT = 8'hF9;

    logic       clk = 1'b0;
    logic       rst, scan_valid, zxuno_regrd, zxuno_regwr;
    logic [7:0] scan_byte, zxuno_addr, din, dout;
    logic       oe, pending;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [9:0]   m_q[$];
    logic         m_ovf, m_ext, m_rel;
    int           m_skip;
    logic [255:0] m_down;

    ps2_key_event_queue #(.DEPTH(DEPTH), .FILTER_REPEAT(1'b1), .REG_DATA(REG_DATA), .REG_STAT(REG_STAT)) dut (
        .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_byte(scan_byte),
        .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr),
        .din(din), .dout(dout), .oe(oe), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_emit(input logic rel, input logic ext, input logic [7:0] code);
        int idx;
        idx = code[7] ? -1 : int'({ext, code[6:0]});
        if (idx >= 0) begin
            if (rel) m_down[idx] = 1'b0;
            else if (m_down[idx]) return;
            else m_down[idx] = 1'b1;
        end
        if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else m_q.push_back({rel, ext, code});
    endtask

    task automatic m_byte(input logic [7:0] b);
        if (m_skip > 0) begin
            m_skip--;
            if (m_skip == 0) m_emit(1'b0, 1'b1, 8'h77);
        end else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_rel = 1'b1;
        else if (b == 8'hE1) begin
            m_skip = 7; m_ext = 1'b0; m_rel = 1'b0;
        end else begin
            m_emit(m_rel, m_ext, b);
            m_ext = 1'b0; m_rel = 1'b0;
        end
    endtask

    function automatic logic [7:0] m_stat();
        logic [9:0] h;
        int         c;
        h = (m_q.size() != 0) ? m_q[0] : 10'd0;
        c = (m_q.size() > 15) ? 15 : m_q.size();
        return {m_ovf, h[9], h[8], (m_q.size() == DEPTH), c[3:0]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; scan_valid = 1'b0; zxuno_regrd = 1'b0; zxuno_regwr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_q.delete(); m_ovf = 1'b0; m_ext = 1'b0; m_rel = 1'b0; m_skip = 0; m_down = '0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        scan_valid = 1'b1; scan_byte = b;
        @(posedge clk); #1;
        scan_valid = 1'b0;
        m_byte(b);
        check_val("pending", {9'd0, pending}, {9'd0, m_q.size() != 0});
    endtask

    task automatic read_stat(output logic [7:0] got);
        @(negedge clk);
        zxuno_addr = REG_STAT; zxuno_regrd = 1'b1;
        #1;
        got = dout;
        check_val("stat", {2'b0, dout}, {2'b0, m_stat()});
        check_val("oe_stat", {9'd0, oe}, 10'd1);
        @(negedge clk);
        zxuno_regrd = 1'b0;
    endtask

    // Holds the DATA read for 'hold' cycles; optionally pushes a byte in the pop cycle.
    task automatic read_data(input int hold, input bit with_push, input logic [7:0] b, output logic [7:0] got);
        logic [7:0] exp;
        @(negedge clk);
        zxuno_addr = REG_DATA; zxuno_regrd = 1'b1;
        #1;
        exp = (m_q.size() != 0) ? m_q[0][7:0] : 8'h00;
        got = dout;
        check_val("data", {2'b0, dout}, {2'b0, exp});
        check_val("oe_data", {9'd0, oe}, 10'd1);
        repeat (hold) @(negedge clk);
        zxuno_regrd = 1'b0;
        if (with_push) begin
            scan_valid = 1'b1; scan_byte = b;
        end
        @(posedge clk); #1;
        scan_valid = 1'b0;
        if (m_q.size() != 0) void'(m_q.pop_front());
        if (with_push) m_byte(b);
        check_val("pending_pop", {9'd0, pending}, {9'd0, m_q.size() != 0});
    endtask

    task automatic write_stat(input logic [7:0] d, input bit with_push, input logic [7:0] b);
        @(negedge clk);
        zxuno_addr = REG_STAT; zxuno_regwr = 1'b1; din = d;
        if (with_push) begin
            scan_valid = 1'b1; scan_byte = b;
        end
        @(posedge clk); #1;
        zxuno_regwr = 1'b0; scan_valid = 1'b0;
        if (with_push) m_byte(b);
        if (d[7]) begin
            m_q.delete(); m_ovf = 1'b0;
        end
        if (d[6]) m_down = '0;
    endtask

    logic [7:0] r;
    logic [7:0] pool [10] = '{8'h1C, 8'h1B, 8'h23, 8'h75, 8'h83, 8'hE0, 8'hF0, 8'h77, 8'h14, 8'h2D};
    logic [7:0] makes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    logic [7:0] pause [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    initial begin
        rst = 1'b1; scan_valid = 1'b0; scan_byte = 8'h00; zxuno_addr = 8'h00;
        zxuno_regrd = 1'b0; zxuno_regwr = 1'b0; din = 8'h00;
        do_reset();
        #1;
        check_val("rst_pending", {9'd0, pending}, 10'd0);
        check_val("rst_dout", {2'b0, dout}, 10'd0);
        check_val("rst_oe", {9'd0, oe}, 10'd0);

        // Make then break of the same key
        send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
        read_stat(r);          check_val("t1_stat0", {2'b0, r}, 10'h02);
        read_data(1, 0, 0, r); check_val("t1_data0", {2'b0, r}, 10'h1C);
        read_stat(r);          check_val("t1_stat1", {2'b0, r}, 10'h41);
        read_data(1, 0, 0, r); check_val("t1_data1", {2'b0, r}, 10'h1C);
        check_val("t1_empty", {9'd0, pending}, 10'd0);

        // Extended make/break and a stray prefix
        do_reset();
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        read_stat(r); check_val("t2_stat0", {2'b0, r}, 10'h22);
        read_data(2, 0, 0, r);
        read_stat(r); check_val("t2_stat1", {2'b0, r}, 10'h61);
        read_data(1, 0, 0, r);
        send_byte(8'hE0);
        check_val("t2_stray", {9'd0, pending}, 10'd0);

        // Typematic repeats dropped
        do_reset();
        repeat (5) send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);
        read_stat(r); check_val("t3_cnt", {2'b0, r}, 10'h02);

        // Overflow, ordered drain, flush
        do_reset();
        foreach (makes[i]) send_byte(makes[i]);
        read_stat(r); check_val("t4_stat", {2'b0, r}, 10'h98);
        for (int i = 0; i < 8; i++) begin
            read_data(1, 0, 0, r);
            check_val("t4_order", {2'b0, r}, {2'b0, makes[i]});
        end
        write_stat(8'h80, 0, 0);
        read_stat(r); check_val("t4_flush", {2'b0, r}, 10'h00);

        // Pause sequence, then normal decode
        do_reset();
        foreach (pause[i]) send_byte(pause[i]);
        read_stat(r); check_val("t5_pause", {2'b0, r}, 10'h21);
        read_data(1, 0, 0, r); check_val("t5_code", {2'b0, r}, 10'h77);
        send_byte(8'h1C);
        read_stat(r); check_val("t5_next", {2'b0, r}, 10'h01);

        // Long strobe with simultaneous push, also at full
        do_reset();
        send_byte(8'h1C); send_byte(8'h1B);
        read_data(4, 1, 8'h23, r);
        read_stat(r); check_val("t6_cnt", {2'b0, r}, 10'h02);
        foreach (makes[i]) if (i < 6) send_byte(makes[i]);
        read_data(3, 1, 8'h44, r);
        read_stat(r); check_val("t6_full", {2'b0, r}, 10'h18);

        // Flush wins over a simultaneous push
        write_stat(8'h80, 1, 8'h83);
        read_stat(r); check_val("t7_flush_push", {2'b0, r}, 10'h00);

        // Reset abandons decoder state mid-prefix and mid-pause
        send_byte(8'hE0);
        do_reset();
        send_byte(8'h1C);
        read_stat(r); check_val("t8_after_e0", {2'b0, r}, 10'h01);
        send_byte(8'hE1); send_byte(8'h14);
        do_reset();
        send_byte(8'h1C);
        read_stat(r); check_val("t8_after_e1", {2'b0, r}, 10'h01);

        // Randomized traffic against the model
        do_reset();
        for (int it = 0; it < 600; it++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 55) begin
                if ($urandom_range(0, 49) == 0) send_byte(8'hE1);
                else send_byte(pool[$urandom_range(0, 9)]);
            end else if (sel < 80) begin
                read_data(int'($urandom_range(1, 3)), $urandom_range(0, 2) == 0, pool[$urandom_range(0, 9)], r);
            end else if (sel < 95) begin
                read_stat(r);
            end else begin
                write_stat({$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 6'd0}, 0, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
